// File: rtl/operand_fetch_stage_pkg.sv
// cpu_pkg: shared opcode encodings, instruction field positions and decode
// helpers for the operand fetch stage and its register file.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_SHL  = 4'b0111,
        OP_SHR  = 4'b1000,
        OP_LDI  = 4'b1011,
        OP_CMP  = 4'b1100,
        OP_ZERO = 4'b1111
    } alu_op_e;

    // Instruction field positions (16-bit instruction word)
    localparam int OP_LSB  = 12;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int REG_W   = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 9;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_LDI, OP_CMP, OP_ZERO: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Load-immediate and zero read no registers; illegal ops read nothing.
    function automatic logic uses_srcs(input logic [OP_W-1:0] op);
        return is_legal_op(op) && (op != OP_LDI) && (op != OP_ZERO);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_regfile.sv
// regfile_2r1w: register file with two asynchronous read ports and one
// synchronous write port. r0 is hardwired to zero. A write in the same cycle
// as a read of the same register is forwarded to the read port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears all regs)
//   ra0/ra1 -> rd0/rd1    read addresses and data
//   we, wa, wd            write enable, address, data
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RW-1:0]     ra0,
    input  logic [RW-1:0]     ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic              we,
    input  logic [RW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [1:NREGS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd0 = '0;
        if (ra0 != '0) rd0 = (we && (wa == ra0)) ? wd : regs[ra0];
    end

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: issue stage in front of the 16-bit ALU. Decodes one
// instruction per cycle, reads operands from the register file, tracks
// in-flight destinations in a pending scoreboard and stalls on RAW hazards.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   instr_valid/instr_ready/instr upstream instruction handshake
//   ex_valid/ex_ready            downstream operand handshake
//   ex_in0/ex_in1/ex_select/ex_rd registered ALU operands, opcode, dest tag
//   wb_en/wb_rd/wb_data          writeback from the ALU result register
//   illegal                      1-cycle pulse after accepting an undefined op
//   stall_count                  saturating count of hazard-stall cycles
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 8,
    parameter int STALL_W = 16,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [15:0]        instr,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [DATA_W-1:0]  ex_in0,
    output logic [DATA_W-1:0]  ex_in1,
    output logic [3:0]         ex_select,
    output logic [RW-1:0]      ex_rd,
    input  logic               wb_en,
    input  logic [RW-1:0]      wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               illegal,
    output logic [STALL_W-1:0] stall_count
);

    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    logic [OP_W-1:0]   op;
    logic [RW-1:0]     rd, rs1, rs2;
    logic [IMM_W-1:0]  imm9;
    logic              legal, srcs;
    logic              sp1, sp2, hazard, accept, issue;
    logic [DATA_W-1:0] rf_rd0, rf_rd1;
    logic [NREGS-1:0]  pending, pending_nxt;

    assign op   = instr[OP_LSB  +: OP_W];
    assign rd   = instr[RD_LSB  +: REG_W];
    assign rs1  = instr[RS1_LSB +: REG_W];
    assign rs2  = instr[RS2_LSB +: REG_W];
    assign imm9 = instr[IMM_LSB +: IMM_W];

    assign legal = is_legal_op(op);
    assign srcs  = uses_srcs(op);

    // A writeback landing this cycle resolves the hazard; the bypass in the
    // register file supplies the value.
    assign sp1 = pending[rs1] & ~(wb_en & (wb_rd == rs1));
    assign sp2 = pending[rs2] & ~(wb_en & (wb_rd == rs2));

    assign hazard      = instr_valid & srcs & (sp1 | sp2);
    assign instr_ready = ~hazard & (~ex_valid | ex_ready);
    assign accept      = instr_valid & instr_ready;
    assign issue       = accept & legal;

    regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra0   (rs1),
        .ra1   (rs2),
        .rd0   (rf_rd0),
        .rd1   (rf_rd1),
        .we    (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    // Clear on writeback first so a same-cycle issue to the same rd wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) pending_nxt[wb_rd] = 1'b0;
        if (issue && (rd != '0)) pending_nxt[rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            ex_valid    <= 1'b0;
            ex_in0      <= '0;
            ex_in1      <= '0;
            ex_select   <= 4'b1111;
            ex_rd       <= '0;
            illegal     <= 1'b0;
            stall_count <= '0;
        end else begin
            pending <= pending_nxt;
            illegal <= accept & ~legal;
            if (issue) begin
                ex_valid  <= 1'b1;
                ex_in0    <= srcs ? rf_rd0 : '0;
                ex_in1    <= (op == OP_LDI) ? {{(DATA_W-IMM_W){1'b0}}, imm9}
                           : (srcs ? rf_rd1 : '0);
                ex_select <= op;
                ex_rd     <= rd;
            end else if (ex_ready) begin
                ex_valid  <= 1'b0;
            end
            if (hazard && (stall_count != '1)) stall_count <= stall_count + STALL_ONE;
        end
    end

endmodule
